// File: rtl/fsqrt_arbiter_ctrl_pkg.sv
// Shared types and constants for the FSQRT arbiter: FSM states, FP64 classes and bit patterns.
package fsqrt_arbiter_ctrl_pkg;

   typedef enum logic [1:0] {StIdle, StEval, StResp} state_e;

   typedef enum logic [2:0] {FpZero, FpInf, FpNan, FpNeg, FpNormal} fp_class_e;

   localparam logic [63:0] FP64_QNAN      = 64'h7FF8_0000_0000_0000;
   localparam logic [63:0] FP64_POS_INF   = 64'h7FF0_0000_0000_0000;
   localparam logic [63:0] FP64_SIGN_MASK = 64'h8000_0000_0000_0000;
   localparam logic [63:0] FP64_EXP_MASK  = 64'h7FF0_0000_0000_0000;

   // Negative nonzero values (including -Inf and negative subnormals) classify as FpNeg.
   function automatic fp_class_e fp64_class(input logic [63:0] x);
      logic      exp_ones;
      logic      exp_zero;
      logic      mant_zero;
      fp_class_e cls;
      exp_ones  = (x & FP64_EXP_MASK) == FP64_EXP_MASK;
      exp_zero  = (x & FP64_EXP_MASK) == 64'd0;
      mant_zero = (x & ~(FP64_SIGN_MASK | FP64_EXP_MASK)) == 64'd0;
      if (exp_ones && !mant_zero)             cls = FpNan;
      else if (exp_zero && mant_zero)         cls = FpZero;
      else if ((x & FP64_SIGN_MASK) != 64'd0) cls = FpNeg;
      else if (exp_ones)                      cls = FpInf;
      else                                    cls = FpNormal;
      return cls;
   endfunction

endpackage

// File: rtl/fsqrt_arbiter_ctrl_if.sv
// Requester and response handshake bundle for the shared FSQRT arbiter.
interface fsqrt_arbiter_ctrl_if #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned IDW  = 1
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*64-1:0] req_x;
   logic               resp_valid;
   logic               resp_ready;
   logic [63:0]        resp_y;
   logic [IDW-1:0]     resp_id;
   logic               busy;

   modport master (
      output req_valid, req_x, resp_ready,
      input  req_ready, resp_valid, resp_y, resp_id, busy
   );

   modport slave (
      input  req_valid, req_x, resp_ready,
      output req_ready, resp_valid, resp_y, resp_id, busy
   );
endinterface

// File: rtl/fsqrt_arbiter_ctrl_fsqrt.sv
// Combinational approximate FP64 square root: truncated restoring root of the significand,
// subnormal inputs flush to zero.
module fsqrt_arbiter_ctrl_fsqrt
   import fsqrt_arbiter_ctrl_pkg::*;
(
   input  logic [63:0] x,
   output logic [63:0] y
);
   logic [105:0] rad;
   logic [57:0]  rem;
   logic [57:0]  trial;
   logic [52:0]  root;
   logic [10:0]  exp_y;

   always_comb begin
      rem   = '0;
      trial = '0;
      root  = '0;
      exp_y = 11'((12'(x[62:52]) + 12'd1023) >> 1);
      // Odd biased exponent means an even unbiased one, so the significand needs one less shift.
      if (x[52]) rad = {1'b0, 1'b1, x[51:0], 52'd0};
      else       rad = {1'b1, x[51:0], 53'd0};
      for (int i = 52; i >= 0; i--) begin
         rem   = {rem[55:0], rad[2*i +: 2]};
         trial = 58'({root, 2'b01});
         if (rem >= trial) begin
            rem  = rem - trial;
            root = {root[51:0], 1'b1};
         end else begin
            root = {root[51:0], 1'b0};
         end
      end
      y = {1'b0, exp_y, root[51:0]};
      unique case (fp64_class(x))
         FpZero:  y = x;
         FpInf:   y = x;
         FpNan:   y = x | 64'h0008_0000_0000_0000;
         FpNeg:   y = FP64_QNAN;
         default: if (x[62:52] == 11'd0) y = 64'd0;
      endcase
   end
endmodule

// File: rtl/fsqrt_arbiter_ctrl.sv
// Round-robin arbiter sharing one FSQRT among NREQ requesters; id-tagged registered response.
// Define FSQRT_SPECIAL_EN to classify operands at accept and bypass FSQRT for special values.
module fsqrt_arbiter_ctrl
   import fsqrt_arbiter_ctrl_pkg::*;
#(
   parameter int unsigned NREQ        = 2,
   parameter int unsigned IDW         = 1,
   parameter int unsigned EVAL_CYCLES = 1
) (
   input logic                clk,
   input logic                rst_n,
   fsqrt_arbiter_ctrl_if.slave bus
);
   state_e         state_q, state_d;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   logic [63:0]    x_q, x_d;
   logic [IDW-1:0] id_q, id_d;
   logic [3:0]     eval_cnt_q, eval_cnt_d;
   logic [63:0]    resp_y_q, resp_y_d;
   logic [IDW-1:0] resp_id_q, resp_id_d;

   logic           win_found;
   logic [IDW-1:0] win_idx;
   logic [63:0]    win_x;
   logic [63:0]    fsqrt_y;
   logic [63:0]    eval_y;
   int             idx;

   fsqrt_arbiter_ctrl_fsqrt u_fsqrt (
      .x (x_q),
      .y (fsqrt_y)
   );

   // Search upward from rr_ptr, wrapping at NREQ rather than 2**IDW.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int k = 0; k < int'(NREQ); k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
         if (!win_found && bus.req_valid[IDW'(idx)]) begin
            win_found = 1'b1;
            win_idx   = IDW'(idx);
         end
      end
      win_x = bus.req_x[64*win_idx +: 64];
   end

`ifdef FSQRT_SPECIAL_EN
   logic        byp_q, byp_d;
   logic [63:0] byp_y_q, byp_y_d;

   always_comb begin
      byp_d   = byp_q;
      byp_y_d = byp_y_q;
      if (state_q == StIdle && win_found) begin
         byp_d = 1'b1;
         unique case (fp64_class(win_x))
            FpZero:       byp_y_d = win_x;
            FpInf:        byp_y_d = FP64_POS_INF;
            FpNan, FpNeg: byp_y_d = FP64_QNAN;
            default: begin
               byp_d   = 1'b0;
               byp_y_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byp_q   <= 1'b0;
         byp_y_q <= '0;
      end else begin
         byp_q   <= byp_d;
         byp_y_q <= byp_y_d;
      end
   end

   assign eval_y = byp_q ? byp_y_q : fsqrt_y;
`else
   assign eval_y = fsqrt_y;
`endif

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      x_d        = x_q;
      id_d       = id_q;
      eval_cnt_d = eval_cnt_q;
      resp_y_d   = resp_y_q;
      resp_id_d  = resp_id_q;
      bus.req_ready = '0;
      unique case (state_q)
         StIdle: begin
            if (win_found) begin
               bus.req_ready[win_idx] = 1'b1;
               x_d        = win_x;
               id_d       = win_idx;
               rr_ptr_d   = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
               eval_cnt_d = 4'(EVAL_CYCLES - 1);
               state_d    = StEval;
            end
         end
         StEval: begin
            if (eval_cnt_q == 4'd0) begin
               resp_y_d  = eval_y;
               resp_id_d = id_q;
               state_d   = StResp;
            end else begin
               eval_cnt_d = eval_cnt_q - 4'd1;
            end
         end
         StResp: begin
            if (bus.resp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         rr_ptr_q   <= '0;
         x_q        <= '0;
         id_q       <= '0;
         eval_cnt_q <= '0;
         resp_y_q   <= '0;
         resp_id_q  <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         x_q        <= x_d;
         id_q       <= id_d;
         eval_cnt_q <= eval_cnt_d;
         resp_y_q   <= resp_y_d;
         resp_id_q  <= resp_id_d;
      end
   end

   assign bus.resp_valid = (state_q == StResp);
   assign bus.busy       = (state_q != StIdle);
   assign bus.resp_y     = resp_y_q;
   assign bus.resp_id    = resp_id_q;
endmodule
